// File: rtl/dti_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dti_pkt_pkg
// Description : Shared types and helpers for the byte-serialising packet
//               transmitter. Provides the opcode type, the FSM state
//               encoding, the length-code constants and the opcode decode
//               functions.
// Revision    : 1.0 - initial release
// ============================================================================
package dti_pkt_pkg;

    typedef logic [4:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    // Length codes carried in opcode[1:0]; total bytes include the header.
    localparam logic [1:0] c_len_code_2  = 2'b00;
    localparam logic [1:0] c_len_code_4  = 2'b01;
    localparam logic [1:0] c_len_code_8  = 2'b10;
    localparam logic [1:0] c_len_code_16 = 2'b11;

    // Total byte count (header + payload) for an opcode.
    function automatic logic [4:0] pkt_len(input opcode_t opcode);
        logic [4:0] len;
        case (opcode[1:0])
            c_len_code_2:  len = 5'd2;
            c_len_code_4:  len = 5'd4;
            c_len_code_8:  len = 5'd8;
            c_len_code_16: len = 5'd16;
            default:       len = 5'd2;
        endcase
        return len;
    endfunction

    // Only opcodes with bit 4 set describe a transmittable packet.
    function automatic logic pkt_opcode_legal(input opcode_t opcode);
        return opcode[4];
    endfunction

endpackage : dti_pkt_pkg
`default_nettype wire

// File: rtl/dti_pkt_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : dti_pkt_byte_tx
// Description : Accepts one packet at a time (5-bit opcode + up to 15
//               payload bytes) and serialises it as a header byte followed
//               by payload bytes onto a wr_req/wr_full push interface that
//               feeds the write port of a width-converting async FIFO.
// Ports       : wr_clk, wr_reset_n (async assert, active low)
//               pkt_valid/pkt_ready/pkt_opcode/pkt_data : packet input
//               wr_req/wr_din/wr_full                   : byte push output
//               busy        : packet in flight
//               err_opcode  : one-cycle pulse when an illegal opcode is dropped
//               pkt_sent_cnt: saturating count of completed packets
// Revision    : 1.0 - initial release
// ============================================================================
module dti_pkt_byte_tx
    import dti_pkt_pkg::*;
#(
    parameter int WR_DATA_WIDTH = 8,
    parameter int PKT_WIDTH     = 128
) (
    input  logic                     wr_clk,
    input  logic                     wr_reset_n,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic [4:0]               pkt_opcode,
    input  logic [PKT_WIDTH-1:0]     pkt_data,
    output logic                     wr_req,
    output logic [WR_DATA_WIDTH-1:0] wr_din,
    input  logic                     wr_full,
    output logic                     busy,
    output logic                     err_opcode,
    output logic [15:0]              pkt_sent_cnt
);

    // At most 15 payload bytes are ever sent, so the top byte of pkt_data
    // is never stored.
    localparam int c_pay_width = PKT_WIDTH - WR_DATA_WIDTH;
    localparam int c_pay_bytes = c_pay_width / WR_DATA_WIDTH;

    state_t                 r_state_q,    w_state_d;
    opcode_t                r_opcode_q,   w_opcode_d;
    logic [c_pay_width-1:0] r_data_q,     w_data_d;
    logic [4:0]             r_len_q,      w_len_d;
    logic [3:0]             r_cnt_q,      w_cnt_d;
    logic                   r_err_q,      w_err_d;
    logic [15:0]            r_sent_cnt_q, w_sent_cnt_d;

    logic                     w_take;
    logic                     w_last;
    logic                     w_accept;
    logic                     w_legal;
    logic [3:0]               w_byte_sel;
    logic [WR_DATA_WIDTH-1:0] w_pay_byte;
    logic [WR_DATA_WIDTH-1:0] w_header;
    logic                     w_unused_top;

    assign w_unused_top = ^pkt_data[PKT_WIDTH-1 -: WR_DATA_WIDTH];

    // ------------------------------------------------------------------
    // Output datapath
    // ------------------------------------------------------------------
    assign wr_req   = (r_state_q != IDLE);
    assign busy     = (r_state_q != IDLE);
    assign w_take   = wr_req && !wr_full;
    assign w_header = WR_DATA_WIDTH'({3'b000, r_opcode_q});

    // In PAY the counter runs 1..len-1 and selects payload byte counter-1.
    assign w_byte_sel = r_cnt_q - 4'd1;

    always_comb begin
        w_pay_byte = '0;
        for (int i = 0; i < c_pay_bytes; i++) begin
            if (w_byte_sel == 4'(i)) begin
                w_pay_byte = r_data_q[i*WR_DATA_WIDTH +: WR_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        wr_din = '0;
        case (r_state_q)
            HDR:     wr_din = w_header;
            PAY:     wr_din = w_pay_byte;
            default: wr_din = '0;
        endcase
    end

    // Last byte: payload byte taken with the counter at len-1. The header
    // can never be last since the shortest packet is two bytes.
    assign w_last = (r_state_q == PAY) && w_take &&
                    ({1'b0, r_cnt_q} == (r_len_q - 5'd1));

    // Ready depends on wr_full only through the last-byte term, which is
    // what allows back-to-back packets without a bubble.
    assign pkt_ready = (r_state_q == IDLE) || w_last;
    assign w_accept  = pkt_valid && pkt_ready;
    assign w_legal   = pkt_opcode_legal(pkt_opcode);

    assign err_opcode   = r_err_q;
    assign pkt_sent_cnt = r_sent_cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_opcode_d   = r_opcode_q;
        w_data_d     = r_data_q;
        w_len_d      = r_len_q;
        w_cnt_d      = r_cnt_q;
        w_err_d      = 1'b0;
        w_sent_cnt_d = r_sent_cnt_q;

        case (r_state_q)
            IDLE: begin
                w_state_d = IDLE;
            end
            HDR: begin
                if (w_take) begin
                    w_state_d = PAY;
                    w_cnt_d   = 4'd1;
                end
            end
            PAY: begin
                if (w_last) begin
                    w_state_d = IDLE;
                    if (r_sent_cnt_q != 16'hFFFF) begin
                        w_sent_cnt_d = r_sent_cnt_q + 16'd1;
                    end
                end else if (w_take) begin
                    w_cnt_d = r_cnt_q + 4'd1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // An accept happens only from IDLE or on the last-byte cycle, both
        // of which otherwise head to IDLE; a legal packet overrides that.
        if (w_accept) begin
            if (w_legal) begin
                w_state_d  = HDR;
                w_opcode_d = pkt_opcode;
                w_data_d   = pkt_data[c_pay_width-1:0];
                w_len_d    = pkt_len(pkt_opcode);
                w_cnt_d    = 4'd0;
            end else begin
                w_err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            r_state_q    <= IDLE;
            r_opcode_q   <= '0;
            r_data_q     <= '0;
            r_len_q      <= '0;
            r_cnt_q      <= '0;
            r_err_q      <= 1'b0;
            r_sent_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_opcode_q   <= w_opcode_d;
            r_data_q     <= w_data_d;
            r_len_q      <= w_len_d;
            r_cnt_q      <= w_cnt_d;
            r_err_q      <= w_err_d;
            r_sent_cnt_q <= w_sent_cnt_d;
        end
    end

endmodule : dti_pkt_byte_tx
`default_nettype wire

// File: doc/dti_pkt_byte_tx.md
# dti_pkt_byte_tx

Byte-serializing packet transmitter that produces the narrow write stream consumed by the byte-to-wide width-converting async FIFO. It accepts one packet at a time: a 5-bit opcode plus up to 15 payload bytes held in a 128-bit word. It emits a header byte followed by the payload bytes over a `wr_req`/`wr_full` push interface. It sits in the write clock domain, directly in front of the FIFO's write port.

## Interface
- `WR_DATA_WIDTH`, default 8: width of the emitted stream. Fixed at 8; any other value is illegal.
- `PKT_WIDTH`, default 128: width of the packet payload input. Must be 16·`WR_DATA_WIDTH`.

Ports:
- `wr_clk`  in  1  clock.
- `wr_reset_n`  in  1  reset, asynchronous assert, active low.
- `pkt_valid`  in  1  packet offered.
- `pkt_ready`  out  1  packet accepted when `pkt_valid && pkt_ready`.
- `pkt_opcode`  in  5  packet opcode.
- `pkt_data`  in  `PKT_WIDTH`  payload; byte 0 is `[7:0]`, sent first.
- `wr_req`  out  1  push request to the FIFO.
- `wr_din`  out  8  push data.
- `wr_full`  in  1  FIFO full; a byte is taken only when `wr_req && !wr_full`.
- `busy`  out  1  packet in flight.
- `err_opcode`  out  1  one-cycle pulse when an illegal opcode is dropped.
- `pkt_sent_cnt`  out  16  count of completed packets; saturates at 0xFFFF.

## Operation
- **Length decode.** `pkt_opcode[4]` must be 1; otherwise the opcode is illegal. Total byte count `len` includes the header and is selected by `pkt_opcode[1:0]`:
  - 00 → 2
  - 01 → 4
  - 10 → 8
  - 11 → 16
- **Header byte** = `{3'b000, pkt_opcode}`.
- **Payload bytes** = `pkt_data` bytes 0 .. `len`-2, in ascending order.
- **States:**
  - IDLE: `pkt_ready`=1, `wr_req`=0. A legal accept loads the opcode, data and `len` into registers, clears the byte counter and goes to HDR. An illegal accept is consumed (`pkt_ready` was 1), pulses `err_opcode` next cycle and stays in IDLE.
  - HDR: `wr_req`=1, `wr_din`=header. On a taken byte go to PAY with counter = 1.
  - PAY: `wr_req`=1, `wr_din`=byte[counter-1]. On a taken byte the counter increments. The taken byte at counter = `len`-1 is the last byte.
- **Last byte taken:** increment `pkt_sent_cnt` (saturating).
  - If `pkt_valid` holds a legal opcode in the same cycle, accept it and go to HDR, giving back-to-back packets with no bubble.
  - Otherwise go to IDLE.
- **`pkt_ready`** = (state==IDLE) OR (last byte being taken this cycle). It is combinational from `wr_full` only in the last-byte case.
- **While `wr_full`=1:** `wr_req` stays 1 and `wr_din` holds. The counter and state do not advance.
- **Payload sampling:** `pkt_data` and `pkt_opcode` are sampled only at accept; later changes are ignored.
- **`busy`** = state != IDLE.
- **Byte counter** is 4 bits and never wraps: its maximum value is `len`-1 ≤ 15.

## Timing
- **Reset values:** state IDLE, `pkt_ready`=1, `wr_req`=0, `wr_din`=0, `busy`=0, `err_opcode`=0, `pkt_sent_cnt`=0.
- **Accept to header:** accept in cycle N → `wr_req`=1 with the header in cycle N+1.
- **Throughput:** with `wr_full`=0 a packet occupies exactly `len` cycles on `wr_req`. Back-to-back packets keep `wr_req` continuously high.
- **Reset mid-packet:** the packet is discarded. All outputs return to reset values asynchronously, and no partial bytes follow after release.
- **Illegal opcode on a last-byte cycle:** the current packet completes normally, the illegal packet is consumed, `err_opcode` pulses the next cycle, and the next state is IDLE.
- **`wr_full` asserted on the header cycle:** the header holds until `wr_full` drops.

## Structure
- **Package `dti_pkt_pkg`:**
  - opcode typedef (5-bit);
  - state enum {IDLE, HDR, PAY};
  - length-code localparams;
  - function `pkt_len(opcode)` returning the 5-bit total byte count;
  - function `pkt_opcode_legal(opcode)`.
- No sub-module; a single FSM plus datapath mux.

## Test plan
1. **Single 8-byte packet, `wr_full`=0.** Opcode 5'b10010 with `pkt_data[55:0]`=0x07_06_05_04_03_02_01 → `wr_din` sequence 0x12,01,02,03,04,05,06,07 on 8 consecutive `wr_req` cycles; `pkt_sent_cnt`=1.
2. **Back-to-back 8/16/8 packets.** Opcodes 10010, 11011, 10010 with `pkt_valid` held → `wr_req` high for 32 continuous cycles; headers 0x12, 0x1B, 0x12 at byte offsets 0, 8, 24; `pkt_sent_cnt`=3.
3. **Backpressure.** 16-byte packet; `wr_full`=1 for 3 cycles on the header and for 2 cycles on byte 9 → each byte is emitted exactly once, `wr_din` is stable during stalls, and completion is 21 cycles after the header first appears.
4. **Illegal opcode.** Opcode 5'b00010 → accepted, no `wr_req`, `err_opcode` pulses once, `pkt_sent_cnt` unchanged. A following legal 2-byte packet (5'b10000, data 0xAA) emits 0x10, 0xAA.
5. **Reset mid-packet.** Assert `wr_reset_n`=0 after byte 3 of a 16-byte packet → `wr_req`=0 and `pkt_ready`=1 immediately; after release no residual bytes are emitted.
6. **Counter saturation.** Preload via 65535 2-byte packets (or a force), then send one more → `pkt_sent_cnt` stays 0xFFFF.
